dot_product_seq: RTL
====================

Name: dot_product_seq

Overview:
- Sequencer directly upstream of the iterative multiplier FSM (start/done/result interface, 32-bit operands).
- Accepts a job of N operand pairs over a valid/ready stream and issues one multiply per pair.
- Accumulates the products and presents the dot-product sum on a valid/ready output.
- Sits between the operand source and the result consumer, and owns the multiplier's start handshake.

Parameters:
- WIDTH, 32, operand, product and sum width; must match the multiplier width.
- LEN_W, 8, width of the job-length field.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- job_start  in  1  one-cycle pulse; honoured only in IDLE. Latches cfg_len.
- cfg_len  in  LEN_W  number of pairs N in the job.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in ACCEPT.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- mul_start  out  1  start pulse to the multiplier.
- mul_a  out  WIDTH  registered operand A to the multiplier.
- mul_b  out  WIDTH  registered operand B to the multiplier.
- mul_result  in  WIDTH  multiplier product; valid while mul_done=1 after completion.
- mul_done  in  1  multiplier done/idle level.
- out_valid  out  1  sum available.
- out_ready  in  1  consumer accepts the sum.
- out_sum  out  WIDTH  accumulated sum, modulo 2^WIDTH.
- out_ovf  out  1  sticky; set if any accumulate carried out of WIDTH bits during the job.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; internal remaining count, sum and ovf cleared. Takes effect immediately, including mid-job. The multiplier is not reset by this block.
- IDLE:
  - job_start=1 and cfg_len!=0: remaining<=cfg_len, sum<=0, ovf<=0, go to ACCEPT.
  - job_start=1 and cfg_len==0: sum<=0, ovf<=0, go to OUTPUT (empty job, sum 0).
  - job_start is ignored in every other state.
- ACCEPT:
  - in_ready=1.
  - On in_valid & in_ready: mul_a<=in_a, mul_b<=in_b, go to ISSUE.
  - No combinational path from in_valid to in_ready.
- ISSUE:
  - mul_start=1 for exactly this one cycle, then go to WAIT_LOW.
  - Issue only while mul_done=1; otherwise hold in ISSUE with mul_start=0.
- WAIT_LOW:
  - Wait for mul_done=0. The multiplier drops done on the edge after it samples start, so a stale high done is never taken as completion.
  - Then go to WAIT_HIGH.
- WAIT_HIGH:
  - On mul_done=1: sum<=sum+mul_result as a (WIDTH+1)-bit add.
  - ovf<=ovf|carry.
  - remaining<=remaining-1.
  - If remaining==1 go to OUTPUT, else go to ACCEPT.
- OUTPUT:
  - out_valid=1; out_sum and out_ovf held stable.
  - On out_ready: go to IDLE, out_valid drops the next cycle.
  - If out_ready is already high on entry, the transfer completes in the first OUTPUT cycle.
- mul_a and mul_b hold their values until the next accepted pair.
- Latency per pair: accept, 1 issue cycle, multiplier latency, 1 accumulate cycle. No pair overlap; only one multiply is in flight.
- Products are taken as WIDTH bits, since the multiplier truncates. The sum wraps at 2^WIDTH and out_ovf flags the wrap.
- cfg_len and in_a/in_b changes outside their sampling points have no effect.

Test Plan:
- Reset, then job_start with cfg_len=3 and pairs (2,3),(4,5),(6,7) against the multiplier model -> out_sum=68, out_ovf=0, exactly 3 mul_start pulses, each one cycle wide.
- cfg_len=0 pulse -> OUTPUT on the next cycle with out_sum=0 and no mul_start. With out_ready=1: out_valid high for exactly 1 cycle, then IDLE.
- cfg_len=2 with pairs (0xFFFFFFFF,1),(1,1) -> out_sum=0, out_ovf=1. A following job (5,0) -> out_sum=0, out_ovf=0, ovf cleared per job.
- Stalls:
  - in_valid low for 4 cycles in ACCEPT, then out_ready held low for 5 cycles -> no state advance while stalled, out_sum stable, result 12 for pair (3,4).
  - job_start pulsed while busy -> ignored, result unchanged.
- Assert reset mid-WAIT_HIGH for pair (9,9) -> immediate IDLE, all outputs 0. Then a fresh job (2,2) -> out_sum=4. Reset the multiplier model alongside.

Source files
------------

// File: rtl/dot_product_seq.sv
// dot_product_seq
//   Sequencer placed directly upstream of an iterative multiplier
//   (start/done/result interface). It accepts a job of N operand pairs on
//   a valid/ready stream, issues one multiply per pair, accumulates the
//   products and presents the sum on a valid/ready output.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low reset
//   job_start  : one-cycle pulse, honoured only while idle; latches cfg_len
//   cfg_len    : number of operand pairs in the job
//   busy       : high whenever the sequencer is not idle
//   in_valid   : operand pair valid
//   in_ready   : sequencer can take an operand pair
//   in_a/in_b  : operand pair
//   mul_start  : start pulse to the multiplier
//   mul_a/b    : registered operands to the multiplier
//   mul_result : multiplier product, valid while mul_done is high
//   mul_done   : multiplier done/idle level
//   out_valid  : sum available
//   out_ready  : consumer takes the sum
//   out_sum    : accumulated sum, modulo 2^WIDTH
//   out_ovf    : sticky carry-out flag for the current job
module dot_product_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_start,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_result,
  input  logic             mul_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_OUTPUT
  } state_t;

  state_t             state, state_n;
  logic [LEN_W-1:0]   remaining, remaining_n;
  logic [WIDTH-1:0]   sum, sum_n;
  logic               ovf, ovf_n;
  logic [WIDTH-1:0]   a_q, a_n;
  logic [WIDTH-1:0]   b_q, b_n;
  logic [WIDTH:0]     acc;

  // One extra bit so the carry out of the WIDTH-bit sum is visible.
  assign acc = {1'b0, sum} + {1'b0, mul_result};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      sum       <= '0;
      ovf       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      sum       <= sum_n;
      ovf       <= ovf_n;
      a_q       <= a_n;
      b_q       <= b_n;
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    sum_n       = sum;
    ovf_n       = ovf;
    a_n         = a_q;
    b_n         = b_q;
    unique case (state)
      S_IDLE: begin
        if (job_start) begin
          sum_n = '0;
          ovf_n = 1'b0;
          if (cfg_len != '0) begin
            remaining_n = cfg_len;
            state_n     = S_ACCEPT;
          end else begin
            state_n = S_OUTPUT;
          end
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          a_n     = in_a;
          b_n     = in_b;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mul_done) state_n = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        // A done level still high from the previous multiply must not be
        // mistaken for completion; wait for the multiplier to drop it.
        if (!mul_done) state_n = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (mul_done) begin
          sum_n       = acc[WIDTH-1:0];
          ovf_n       = ovf | acc[WIDTH];
          remaining_n = remaining - LEN_W'(1);
          state_n     = (remaining == LEN_W'(1)) ? S_OUTPUT : S_ACCEPT;
        end
      end
      S_OUTPUT: begin
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign in_ready  = (state == S_ACCEPT);
  assign mul_start = (state == S_ISSUE) && mul_done;
  assign out_valid = (state == S_OUTPUT);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign out_sum   = sum;
  assign out_ovf   = ovf;

endmodule
